xbus_mcast_sched: RTL and testbench
===================================

Name: xbus_mcast_sched

Overview:
Multicast scheduler for the horizontal X data bus feeding one row of glb_PE columns. It buffers tagged words from the global buffer side in a small FIFO and holds a per-column ID table. It drives each head word onto the shared bus with a per-column enable for every column whose ID equals the word's tag. It retires a word only when all targeted columns are ready, so delivery is all-or-nothing.

Parameters:
DATA_WIDTH, 16, bus data width
NUM_COL, 3, number of PE columns on the bus
ID_WIDTH, 4, width of column ID and word tag
FIFO_DEPTH, 4, input buffer entries; power of two, >=2

Ports:
clk  in  1  single clock
rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous flush request
cfg_we  in  1  write column ID
cfg_col  in  $clog2(NUM_COL)  column index for cfg_we
cfg_id  in  ID_WIDTH  ID value to write
cfg_done  in  1  end configuration, enter RUN
in_valid  in  1  input word valid
in_ready  out  1  input accept
in_data  in  DATA_WIDTH  input word
in_tag  in  ID_WIDTH  destination tag
bus_data  out  DATA_WIDTH  shared X bus data
bus_en  out  NUM_COL  per-column enable
pe_ready  in  NUM_COL  per-column ready
busy  out  1  FIFO non-empty in RUN
rst_busy  out  1  flush in progress
nomatch  out  1  one-cycle pulse: word dropped, no column matched

Behaviour:
- Reset (async, rstn=0): state=CFG; FIFO empty, pointers 0; all ID regs = all-ones; in_ready=0, bus_en=0, bus_data=0, busy=0, rst_busy=0, nomatch=0. Applies immediately, including mid-transfer.
- States are CFG, RUN and FLUSH.
- CFG:
  - cfg_we writes id[cfg_col]; cfg_col>=NUM_COL is ignored.
  - in_ready=0 and bus_en=0.
  - cfg_done moves to RUN next cycle. If cfg_we and cfg_done occur together, the write is kept.
- RUN:
  - cfg_we is ignored (IDs locked).
  - in_ready = !full (no pass-through when full).
  - Push on in_valid&in_ready. Simultaneous push and pop is legal; count is unchanged.
  - A word accepted at edge k appears at the FIFO head from cycle k+1 at the earliest. There is no same-cycle bypass.
  - match[i] = (id[i]==head_tag). bus_data = head data. bus_en = head_valid ? match : 0 (combinational from the registered head).
  - Fire when head_valid & match!=0 & (pe_ready&match)==match; pop at that edge. Next head is visible the following cycle, so back-to-back is 1 word/cycle.
  - Partial ready: bus_en and bus_data stay stable and nothing pops. No column is ever delivered a word twice.
  - match==0: the head is dropped at the next edge. nomatch is registered and pulses the cycle after the drop.
  - Pointers wrap modulo FIFO_DEPTH. full is count==FIFO_DEPTH; empty is count==0.
  - busy = !empty.
- FLUSH:
  - flush sampled high in any state enters FLUSH. Flush has priority over push, pop and cfg in that cycle.
  - FLUSH lasts exactly 2 cycles with rst_busy=1, in_ready=0, bus_en=0.
  - The FIFO is emptied; ID regs are retained.
  - Afterwards the block returns to the pre-flush state (CFG or RUN).
  - flush held high keeps the block in FLUSH and restarts the 2-cycle count.
  - busy=0 during FLUSH.
- Tag all-ones equals the reset ID value. A tag of all-ones therefore matches unconfigured columns; software must not use it.

Test Plan:
1. Reset, cfg id={2,2,5}, cfg_done; push 0x1234 tag 2 with pe_ready=3'b111 -> next cycle bus_en=3'b011, bus_data=0x1234, pop same cycle; busy 1 for exactly one cycle.
2. Tag 2 word, pe_ready=3'b001 for 3 cycles then 3'b011 -> bus_en=3'b011 and data held 4 cycles, single pop, in_ready stays 1.
3. Push 0xBEEF tag 7 -> bus_en=0, entry dropped after 1 cycle, nomatch=1 one cycle later; following tag-5 word gives bus_en=3'b100.
4. pe_ready=0; offer 5 words (0x1..0x5) tag 5 -> in_ready=0 after the 4th accept. Then pe_ready=3'b100 -> 0x1..0x4 on bus on consecutive cycles in order, 0x5 accepted after the first pop, pointers wrap, busy drops after 0x5.
5. 3 entries queued, pulse flush -> rst_busy=1 for 2 cycles, bus_en=0, busy=0, back to RUN. IDs retained: new tag-2 word -> bus_en=3'b011. Also flush asserted with cfg_done in CFG -> remains CFG after flush.
6. rstn low mid-transfer (bus_en=3'b011 held) -> all outputs 0 immediately, state CFG, IDs all-ones. cfg_we in RUN after re-config has no effect on routing.

Source files
------------

// File: rtl/xbus_mcast_sched.sv
// Multicast scheduler for the horizontal X bus of one glb_PE row.
// Words from the global buffer are queued in a small FIFO. The head word is
// driven onto the shared bus together with an enable for every column whose
// configured ID equals the word's tag. The word retires only when every
// targeted column is ready, so a word reaches either all its columns or none.
module xbus_mcast_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 3,
  parameter int ID_WIDTH   = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int COL_W     = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  cfg_we,
  input  logic [COL_W-1:0]      cfg_col,
  input  logic [ID_WIDTH-1:0]   cfg_id,
  input  logic                  cfg_done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ID_WIDTH-1:0]   in_tag,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic [NUM_COL-1:0]    bus_en,
  input  logic [NUM_COL-1:0]    pe_ready,
  output logic                  busy,
  output logic                  rst_busy,
  output logic                  nomatch
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [COL_W:0]   NUM_COL_V = (COL_W + 1)'(NUM_COL);

  typedef enum logic [1:0] {
    S_CFG   = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                state;
  state_t                ret_state;
  state_t                nstate;
  logic                  flush_cnt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      ncount;
  logic [ID_WIDTH-1:0]   id_tab   [NUM_COL];
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]   mem_tag  [FIFO_DEPTH];

  logic                  head_valid;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ID_WIDTH-1:0]   head_tag;
  logic [NUM_COL-1:0]    match;
  logic                  push;
  logic                  fire;
  logic                  drop;
  logic                  pop;
  logic                  id_wr;

  // Head decode: column match, bus drive and the handshake events of this cycle
  always_comb begin
    head_valid = (state == S_RUN) && (count != '0);
    head_data  = mem_data[rd_ptr];
    head_tag   = mem_tag[rd_ptr];
    match      = '0;
    for (int i = 0; i < NUM_COL; i++) begin
      match[i] = (id_tab[i] == head_tag);
    end
    bus_en   = head_valid ? match : '0;
    bus_data = head_valid ? head_data : '0;
    // flush wins over every other action sampled in the same cycle
    push  = (state == S_RUN) && !flush && in_valid && in_ready;
    fire  = head_valid && (match != '0) && ((pe_ready & match) == match);
    drop  = head_valid && (match == '0);
    pop   = !flush && (fire || drop);
    id_wr = (state == S_CFG) && !flush && cfg_we && ({1'b0, cfg_col} < NUM_COL_V);
  end

  // Next state and next occupancy, used both for the state update and to
  // pre-compute the registered status outputs
  always_comb begin
    nstate = state;
    ncount = count;
    if (flush) begin
      nstate = S_FLUSH;
      ncount = '0;
    end else begin
      case (state)
        S_CFG: begin
          if (cfg_done) nstate = S_RUN;
        end
        S_RUN: begin
          case ({push, pop})
            2'b10:   ncount = count + CNT_W'(1);
            2'b01:   ncount = count - CNT_W'(1);
            default: ncount = count;
          endcase
        end
        S_FLUSH: begin
          if (flush_cnt) nstate = ret_state;
        end
        default: nstate = S_CFG;
      endcase
    end
  end

  // Control FSM: mode, FIFO pointers, ID table and registered status outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_CFG;
      ret_state <= S_CFG;
      flush_cnt <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      rst_busy  <= 1'b0;
      nomatch   <= 1'b0;
      for (int i = 0; i < NUM_COL; i++) begin
        id_tab[i] <= '1;
      end
    end else begin
      state    <= nstate;
      count    <= ncount;
      in_ready <= (nstate == S_RUN) && (ncount != FULL_CNT);
      busy     <= (nstate == S_RUN) && (ncount != '0);
      rst_busy <= (nstate == S_FLUSH);
      nomatch  <= !flush && drop;
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        flush_cnt <= 1'b0;
        // a restarted flush keeps the mode it will eventually return to
        if (state != S_FLUSH) ret_state <= state;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (state == S_FLUSH) flush_cnt <= 1'b1;
        if (id_wr) id_tab[cfg_col] <= cfg_id;
      end
    end
  end

  // FIFO storage: payload only, written on an accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_tag[wr_ptr]  <= in_tag;
    end
  end

endmodule

// File: tb/tb_xbus_mcast_sched.sv
// Bench for xbus_mcast_sched: directed scenarios followed by randomized
// traffic, every cycle compared against a queue-based behavioural model.
module tb_xbus_mcast_sched;

  localparam int DW = 16;
  localparam int NC = 3;
  localparam int IW = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_col = '0;
  logic [IW-1:0] cfg_id = '0;
  logic          cfg_done = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [IW-1:0] in_tag = '0;
  logic [DW-1:0] bus_data;
  logic [NC-1:0] bus_en;
  logic [NC-1:0] pe_ready = '0;
  logic          busy;
  logic          rst_busy;
  logic          nomatch;

  int n_checks = 0;
  int n_fail   = 0;

  xbus_mcast_sched #(
    .DATA_WIDTH(DW), .NUM_COL(NC), .ID_WIDTH(IW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .cfg_we(cfg_we), .cfg_col(cfg_col),
    .cfg_id(cfg_id), .cfg_done(cfg_done), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag), .bus_data(bus_data), .bus_en(bus_en),
    .pe_ready(pe_ready), .busy(busy), .rst_busy(rst_busy), .nomatch(nomatch)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] t;
  } word_t;

  int            m_mode;     // 0 configure, 1 run, 2 flushing
  int            m_ret;
  int            m_fl_left;
  logic [IW-1:0] m_id [NC];
  word_t         m_q [$];
  logic          m_nm;
  logic          m_acc;      // word offered this cycle was accepted

  function automatic logic [NC-1:0] m_match(logic [IW-1:0] tag);
    logic [NC-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) r[i] = (m_id[i] == tag);
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_ret = 0;
    m_fl_left = 0;
    m_q.delete();
    for (int i = 0; i < NC; i++) m_id[i] = '1;
    m_nm = 1'b0;
    m_acc = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0;
    cfg_we = 1'b0;
    cfg_done = 1'b0;
    in_valid = 1'b0;
  endtask

  // One clock: compare outputs against the model, then advance the model
  task automatic step();
    logic          exp_rdy;
    logic [NC-1:0] exp_en;
    logic [DW-1:0] exp_data;
    logic          hv;
    logic [NC-1:0] mt;
    logic          nm;
    exp_rdy  = (m_mode == 1) && (m_q.size() < FD);
    hv       = (m_mode == 1) && (m_q.size() > 0);
    exp_en   = hv ? m_match(m_q[0].t) : '0;
    exp_data = hv ? m_q[0].d : '0;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("bus_en", 32'(bus_en), 32'(exp_en));
    if (hv) chk("bus_data", 32'(bus_data), 32'(exp_data));
    chk("busy", 32'(busy), 32'(hv));
    chk("rst_busy", 32'(rst_busy), 32'(m_mode == 2));
    chk("nomatch", 32'(nomatch), 32'(m_nm));
    m_acc = exp_rdy && in_valid && !flush;
    if (flush) begin
      if (m_mode != 2) m_ret = m_mode;
      m_mode = 2;
      m_fl_left = 2;
      m_q.delete();
      m_nm = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          if (cfg_we && cfg_col < NC) m_id[cfg_col] = cfg_id;
          if (cfg_done) m_mode = 1;
          m_nm = 1'b0;
        end
        1: begin
          nm = 1'b0;
          if (m_q.size() > 0) begin
            mt = m_match(m_q[0].t);
            if (mt == '0) begin
              void'(m_q.pop_front());
              nm = 1'b1;
            end else if ((pe_ready & mt) == mt) begin
              void'(m_q.pop_front());
            end
          end
          if (m_acc) m_q.push_back({in_data, in_tag});
          m_nm = nm;
        end
        default: begin
          m_fl_left--;
          if (m_fl_left == 0) m_mode = m_ret;
          m_nm = 1'b0;
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once
  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_bus_en", 32'(bus_en), 32'h0);
    chk("rst_bus_data", 32'(bus_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rst_busy", 32'(rst_busy), 32'h0);
    chk("rst_nomatch", 32'(nomatch), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic cfg_write(input logic [1:0] col, input logic [IW-1:0] id);
    cfg_we = 1'b1;
    cfg_col = col;
    cfg_id = id;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic std_config();
    cfg_write(2'd0, 4'd2);
    cfg_write(2'd1, 4'd2);
    cfg_write(2'd2, 4'd5);
    cfg_done = 1'b1;
    step();
    cfg_done = 1'b0;
  endtask

  // Offer one word until accepted (bounded)
  task automatic push_word(input logic [DW-1:0] d, input logic [IW-1:0] t);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_tag = t;
    do begin
      step();
      n++;
    end while (!m_acc && n < 50);
    chk("push_accepted", 32'(m_acc), 32'h1);
    in_valid = 1'b0;
  endtask

  initial begin
    int widx;
    int guard;
    model_reset();
    idle_inputs();
    #3;

    // 1: basic multicast to columns 0 and 1
    do_reset();
    std_config();
    pe_ready = 3'b111;
    push_word(16'h1234, 4'd2);
    repeat (3) step();

    // 2: partial ready holds the word
    pe_ready = 3'b001;
    push_word(16'hA5A5, 4'd2);
    repeat (3) step();
    pe_ready = 3'b011;
    repeat (2) step();

    // 3: unmatched tag dropped, then tag 5 to column 2
    pe_ready = 3'b111;
    push_word(16'hBEEF, 4'd7);
    push_word(16'h0055, 4'd5);
    repeat (3) step();

    // 4: fill to full with no ready, then drain with wrap
    pe_ready = 3'b000;
    widx = 1;
    guard = 0;
    in_valid = 1'b1;
    while (widx <= 5 && guard < 40) begin
      in_data = 16'(widx);
      in_tag = 4'd5;
      if (guard == 8) pe_ready = 3'b100;
      step();
      if (m_acc) widx++;
      guard++;
    end
    chk("fill_done", 32'(widx), 32'd6);
    in_valid = 1'b0;
    pe_ready = 3'b100;
    repeat (8) step();

    // 5: flush with queued entries, IDs retained
    pe_ready = 3'b000;
    push_word(16'h0101, 4'd2);
    push_word(16'h0202, 4'd5);
    push_word(16'h0303, 4'd2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (3) step();
    pe_ready = 3'b111;
    push_word(16'h0404, 4'd2);
    repeat (2) step();
    // flush held for several cycles restarts the count
    flush = 1'b1;
    repeat (3) step();
    flush = 1'b0;
    repeat (3) step();
    // flush together with cfg_done stays in configuration
    do_reset();
    flush = 1'b1;
    cfg_done = 1'b1;
    step();
    flush = 1'b0;
    cfg_done = 1'b0;
    repeat (3) step();
    in_valid = 1'b1;
    in_data = 16'h7777;
    in_tag = 4'd2;
    repeat (2) step();
    in_valid = 1'b0;

    // 6: reset mid-transfer, then unconfigured IDs and locked table
    cfg_done = 1'b1;
    step();
    cfg_done = 1'b0;
    do_reset();
    std_config();
    pe_ready = 3'b001;
    push_word(16'hCAFE, 4'd2);
    step();
    do_reset();
    cfg_done = 1'b1;
    step();
    cfg_done = 1'b0;
    pe_ready = 3'b111;
    push_word(16'hFFFF, 4'hF);
    repeat (2) step();
    do_reset();
    std_config();
    cfg_write(2'd0, 4'd7);
    cfg_write(2'd2, 4'd2);
    push_word(16'h2222, 4'd2);
    push_word(16'h7070, 4'd7);
    repeat (3) step();

    // Randomized traffic
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int c = 0; c < 5; c++) begin
        cfg_we = 1'($urandom_range(0, 1));
        cfg_col = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0: cfg_id = 4'd2;
          1: cfg_id = 4'd5;
          2: cfg_id = 4'd7;
          default: cfg_id = 4'($urandom);
        endcase
        step();
      end
      cfg_we = 1'b0;
      cfg_done = 1'b1;
      step();
      cfg_done = 1'b0;
      for (int c = 0; c < 400; c++) begin
        in_valid = 1'($urandom_range(0, 3) != 0);
        in_data = 16'($urandom);
        case ($urandom_range(0, 3))
          0: in_tag = 4'd2;
          1: in_tag = 4'd5;
          2: in_tag = 4'd7;
          default: in_tag = 4'($urandom);
        endcase
        pe_ready = 3'($urandom);
        flush = ($urandom_range(0, 49) == 0);
        cfg_we = ($urandom_range(0, 9) == 0);
        cfg_col = 2'($urandom_range(0, 2));
        cfg_id = 4'($urandom);
        cfg_done = 1'($urandom_range(0, 1));
        step();
      end
      idle_inputs();
      repeat (4) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
